// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: aluop codes, byte-enable type, FSM states.
package lsu_pkg;

   localparam int ALUOP_W = 8;
   typedef logic [ALUOP_W-1:0] alu_op_t;
   typedef logic [3:0]         be_t;

   localparam alu_op_t EXE_NOP = 8'h00;
   localparam alu_op_t EXE_ADD = 8'h20;
   localparam alu_op_t EXE_LB  = 8'he0;
   localparam alu_op_t EXE_LH  = 8'he1;
   localparam alu_op_t EXE_LW  = 8'he3;
   localparam alu_op_t EXE_LBU = 8'he4;
   localparam alu_op_t EXE_LHU = 8'he5;
   localparam alu_op_t EXE_SB  = 8'he8;
   localparam alu_op_t EXE_SH  = 8'he9;
   localparam alu_op_t EXE_SW  = 8'heb;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_REQ  = 2'd1,
      LSU_WAIT = 2'd2,
      LSU_DONE = 2'd3
   } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational data path of the LSU: op decode, misalignment check,
// store lane formatting and load extraction/extension.
module lsu_align
   import lsu_pkg::*;
(
   input  alu_op_t     aluop,
   input  logic [31:0] addr,
   input  logic [31:0] reg2,
   input  logic [31:0] rdata,
   output logic        is_mem,
   output logic        is_load,
   output logic        misalign,
   output be_t         be,
   output logic [31:0] wdata,
   output logic [31:0] ld_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[7:0];
      unique case (addr[1:0])
         2'd0: byte_sel = rdata[7:0];
         2'd1: byte_sel = rdata[15:8];
         2'd2: byte_sel = rdata[23:16];
         2'd3: byte_sel = rdata[31:24];
      endcase
      half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      is_mem   = 1'b0;
      is_load  = 1'b0;
      misalign = 1'b0;
      be       = 4'b0000;
      wdata    = 32'h0;
      ld_data  = 32'h0;
      case (aluop)
         EXE_LB: begin
            is_mem = 1'b1; is_load = 1'b1; be = 4'b1111;
            ld_data = {{24{byte_sel[7]}}, byte_sel};
         end
         EXE_LBU: begin
            is_mem = 1'b1; is_load = 1'b1; be = 4'b1111;
            ld_data = {24'h0, byte_sel};
         end
         EXE_LH: begin
            is_mem = 1'b1; is_load = 1'b1; be = 4'b1111; misalign = addr[0];
            ld_data = {{16{half_sel[15]}}, half_sel};
         end
         EXE_LHU: begin
            is_mem = 1'b1; is_load = 1'b1; be = 4'b1111; misalign = addr[0];
            ld_data = {16'h0, half_sel};
         end
         EXE_LW: begin
            is_mem = 1'b1; is_load = 1'b1; be = 4'b1111; misalign = |addr[1:0];
            ld_data = rdata;
         end
         EXE_SB: begin
            is_mem = 1'b1;
            be     = 4'b0001 << addr[1:0];
            wdata  = {4{reg2[7:0]}};
         end
         EXE_SH: begin
            is_mem = 1'b1; misalign = addr[0];
            be     = addr[1] ? 4'b1100 : 4'b0011;
            wdata  = {2{reg2[15:0]}};
         end
         EXE_SW: begin
            is_mem = 1'b1; misalign = |addr[1:0];
            be     = 4'b1111;
            wdata  = reg2;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: request/grant/rvalid bus sequencing with pipeline stall,
// pass-through of non-memory results to write-back.
module lsu
   import lsu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  alu_op_t     mem_aluop_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_reg2_i,
   input  logic [4:0]  wd_i,
   input  logic        wreg_i,
   input  logic [31:0] wdata_i,
   output logic [4:0]  wd_o,
   output logic        wreg_o,
   output logic [31:0] wdata_o,
   output logic        stallreq_o,
   output logic        misalign_o,
   output logic        dbus_req_o,
   output logic        dbus_we_o,
   output logic [31:0] dbus_addr_o,
   output be_t         dbus_be_o,
   output logic [31:0] dbus_wdata_o,
   input  logic        dbus_gnt_i,
   input  logic        dbus_rvalid_i,
   input  logic [31:0] dbus_rdata_i
);

   lsu_state_e  state, state_nxt;
   logic [31:0] ld_q;
   logic        is_mem, is_load, misalign, issue;
   be_t         be;
   logic [31:0] st_wdata, ld_data;

   lsu_align u_align (
      .aluop    (mem_aluop_i),
      .addr     (mem_addr_i),
      .reg2     (mem_reg2_i),
      .rdata    (dbus_rdata_i),
      .is_mem   (is_mem),
      .is_load  (is_load),
      .misalign (misalign),
      .be       (be),
      .wdata    (st_wdata),
      .ld_data  (ld_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= LSU_IDLE;
         ld_q  <= 32'h0;
      end else begin
         state <= state_nxt;
         if (state == LSU_WAIT && dbus_rvalid_i) ld_q <= ld_data;
      end
   end

   always_comb begin
      state_nxt    = state;
      issue        = 1'b0;
      wd_o         = wd_i;
      wreg_o       = wreg_i;
      wdata_o      = wdata_i;
      stallreq_o   = 1'b0;
      misalign_o   = 1'b0;
      dbus_req_o   = 1'b0;
      dbus_we_o    = 1'b0;
      dbus_addr_o  = 32'h0;
      dbus_be_o    = 4'b0000;
      dbus_wdata_o = 32'h0;
      unique case (state)
         LSU_IDLE: begin
            if (is_mem) begin
               wreg_o = 1'b0;
               if (misalign) misalign_o = 1'b1;
               else          issue      = 1'b1;
            end
         end
         LSU_REQ: begin
            wreg_o = 1'b0;
            issue  = 1'b1;
         end
         LSU_WAIT: begin
            wreg_o     = 1'b0;
            stallreq_o = 1'b1;
            if (dbus_rvalid_i) state_nxt = LSU_DONE;
         end
         LSU_DONE: begin
            state_nxt = LSU_IDLE;
            if (is_load) wdata_o = ld_q;
            else         wreg_o  = 1'b0;
         end
      endcase
      // IDLE and REQ share the request drive and the grant exits
      if (issue) begin
         stallreq_o   = 1'b1;
         dbus_req_o   = 1'b1;
         dbus_we_o    = !is_load;
         dbus_addr_o  = {mem_addr_i[31:2], 2'b00};
         dbus_be_o    = be;
         dbus_wdata_o = st_wdata;
         if (dbus_gnt_i) state_nxt = is_load ? LSU_WAIT : LSU_DONE;
         else            state_nxt = LSU_REQ;
      end
      // outputs held at their reset values for the whole reset assertion
      if (!rst) begin
         wd_o         = 5'd0;
         wreg_o       = 1'b0;
         wdata_o      = 32'h0;
         stallreq_o   = 1'b0;
         misalign_o   = 1'b0;
         dbus_req_o   = 1'b0;
         dbus_we_o    = 1'b0;
         dbus_addr_o  = 32'h0;
         dbus_be_o    = 4'b0000;
         dbus_wdata_o = 32'h0;
      end
   end

endmodule
